// File: rtl/mult_div_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Optional build macro: DIV_ZERO_EXC_EN (divide-by-zero trap path).
package mult_div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MULT,
    DIV,
    FIX,
    DONE
  } state_e;

  localparam int ITER  = 32;
  localparam int CNT_W = 6;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // 33-bit magnitude so that -2^31 maps cleanly onto 2^31
  function automatic logic [32:0] mag33(input logic [31:0] v);
    logic [32:0] ext;
    ext = {v[31], v};
    return v[31] ? (~ext + 33'd1) : ext;
  endfunction

endpackage

// File: rtl/mult_div_sign_fix.sv
// Sign correction of the unsigned mult/div results.
// Product and quotient follow sign(A)^sign(B), remainder follows sign(A).
module mult_div_sign_fix (
  input  logic [63:0] prod_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] rem_i,
  input  logic        sa_i,
  input  logic        sb_i,
  output logic [63:0] prod_o,
  output logic [31:0] quo_o,
  output logic [31:0] rem_o
);

  logic neg;

  assign neg = sa_i ^ sb_i;

  // conditional two's-complement negation
  always_comb begin
    prod_o = neg  ? (~prod_i + 64'd1) : prod_i;
    quo_o  = neg  ? (~quo_i + 32'd1)  : quo_i;
    rem_o  = sa_i ? (~rem_i + 32'd1)  : rem_i;
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed 32x32 multiply / 32/32 divide, one bit per cycle.
// Optional build macro: DIV_ZERO_EXC_EN (divide-by-zero trap path).
module mult_div_unit
  import mult_div_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        MultStart,
  input  logic        DivStart,
  input  logic [31:0] A_out,
  input  logic [31:0] B_out,
  output logic [31:0] HI_out,
  output logic [31:0] LO_out,
  output logic        MultDivDone,
  output logic        Busy,
  output logic        Div0
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             op_q;
  logic             sa_q;
  logic             sb_q;
  logic             bz_q;
  logic [31:0]      a_q;
  logic [63:0]      prod_q;
  logic [63:0]      mcand_q;
  logic [32:0]      mplier_q;
  logic [32:0]      rem_q;
  logic [31:0]      quo_q;
  logic [32:0]      dvs_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic             done_q;
  logic             busy_q;

  logic [32:0]      mag_a;
  logic [32:0]      mag_b;
  logic             last;
  logic [63:0]      prod_d;
  logic [33:0]      rem_sh;
  logic             ge;
  logic [32:0]      rem_d;
  logic [31:0]      quo_d;
  logic [63:0]      prod_fix;
  logic [31:0]      quo_fix;
  logic [31:0]      rem_fix;

  assign mag_a = mag33(A_out);
  assign mag_b = mag33(B_out);
  assign last  = (cnt_q == CNT_W'(ITER - 1));

  // one shift-add step and one restoring-division step
  always_comb begin
    prod_d = prod_q;
    if (mplier_q[0]) begin
      prod_d = prod_q + mcand_q;
    end
    rem_sh = {rem_q, quo_q[31]};
    ge     = (rem_sh >= {1'b0, dvs_q});
    rem_d  = rem_sh[32:0] - (ge ? dvs_q : 33'd0);
    quo_d  = {quo_q[30:0], ge};
  end

  mult_div_sign_fix u_fix (
    .prod_i (prod_q),
    .quo_i  (quo_q),
    .rem_i  (rem_q[31:0]),
    .sa_i   (sa_q),
    .sb_i   (sb_q),
    .prod_o (prod_fix),
    .quo_o  (quo_fix),
    .rem_o  (rem_fix)
  );

`ifdef DIV_ZERO_EXC_EN
  logic div0_q;
`endif

  // control FSM, iteration datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MULT;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      bz_q     <= 1'b0;
      a_q      <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef DIV_ZERO_EXC_EN
      div0_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef DIV_ZERO_EXC_EN
      div0_q <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (MultStart || DivStart) begin
            op_q     <= MultStart ? OP_MULT : OP_DIV;
            sa_q     <= A_out[31];
            sb_q     <= B_out[31];
            bz_q     <= (B_out == 32'd0);
            a_q      <= A_out;
            prod_q   <= '0;
            mcand_q  <= {31'd0, mag_a};
            mplier_q <= mag_b;
            rem_q    <= '0;
            quo_q    <= mag_a[31:0];
            dvs_q    <= mag_b;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            if (MultStart) begin
              state_q <= MULT;
`ifdef DIV_ZERO_EXC_EN
            end else if (B_out == 32'd0) begin
              state_q <= DONE;
              div0_q  <= 1'b1;
`endif
            end else begin
              state_q <= DIV;
            end
          end
        end
        MULT: begin
          prod_q   <= prod_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= last ? '0 : cnt_q + CNT_W'(1);
          if (last) begin
            state_q <= FIX;
          end
        end
        DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= last ? '0 : cnt_q + CNT_W'(1);
          if (last) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          if (op_q == OP_MULT) begin
            hi_q <= prod_fix[63:32];
            lo_q <= prod_fix[31:0];
          end else if (bz_q) begin
            hi_q <= a_q;
            lo_q <= 32'hFFFF_FFFF;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign HI_out      = hi_q;
  assign LO_out      = lo_q;
  assign MultDivDone = done_q;
  assign Busy        = busy_q;
`ifdef DIV_ZERO_EXC_EN
  assign Div0        = div0_q;
`else
  assign Div0        = 1'b0;
`endif

endmodule
